mfp_timer_gen: RTL and testbench

//  Parametrised MFP68901-style timer channel running directly in the timer clock domain (XCLK_I).

---
 rtl/mfp_timer_pkg.sv | 27 ++
 rtl/mfp_timer_prescaler.sv | 27 ++
 rtl/mfp_timer_gen.sv | 136 +++++++++++++
 tb/tb_mfp_timer_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_timer_pkg.sv
// Shared encodings and the prescaler divider table for the MFP timer channel.
package mfp_timer_pkg;

    localparam logic [3:0] MODE_STOP  = 4'd0;
    localparam logic [3:0] MODE_EVENT = 4'd8;

    localparam int unsigned CTRL_FORCE_TO = 4;
    localparam int unsigned CTRL_ONESHOT  = 5;
    localparam int unsigned CTRL_POL      = 6;

    // Divider for delay/pulse modes; index is mode[2:0], 0 never selects a running mode.
    function automatic logic [7:0] prescale_div(input logic [2:0] mode);
        logic [7:0] div;
        unique case (mode)
            3'd1:    div = 8'd4;
            3'd2:    div = 8'd10;
            3'd3:    div = 8'd16;
            3'd4:    div = 8'd50;
            3'd5:    div = 8'd64;
            3'd6:    div = 8'd100;
            3'd7:    div = 8'd200;
            default: div = 8'd4;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/mfp_timer_prescaler.sv
// Free-running XCLK_I prescaler: one-cycle tick when the count reaches div-1.
module mfp_timer_prescaler (
    input  logic       XCLK_I,
    input  logic       RST,
    input  logic       en,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] count_q;
    logic       at_end;

    // >= so a switch to a smaller divider cannot strand the count above the new limit
    assign at_end = (count_q >= (div - 8'd1));
    assign tick   = en & at_end;

    always_ff @(posedge XCLK_I) begin
        if (RST || !en) begin
            count_q <= 8'd0;
        end else if (at_end) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/mfp_timer_gen.sv
// MFP68901-style timer channel: delay, event and pulse modes with one-shot and read latch.
module mfp_timer_gen
    import mfp_timer_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ONESHOT_EN  = 1
) (
    input  logic             XCLK_I,
    input  logic             RST,
    input  logic             DAT_WE,
    input  logic [WIDTH-1:0] DAT_I,
    output logic [WIDTH-1:0] DAT_O,
    input  logic             RD_HOLD,
    input  logic             CTRL_WE,
    input  logic [6:0]       CTRL_I,
    output logic [5:0]       CTRL_O,
    input  logic             T_I,
    output logic             DELAY_MODE,
    output logic             T_O,
    output logic             T_O_PULSE,
    output logic [WIDTH-1:0] SET_DATA_OUT
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [3:0]             mode_q, mode_d;
    logic                   oneshot_q, oneshot_d;
    logic                   pol_q, pol_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       dat_o_q;
    logic                   to_q, to_d;
    logic                   pulse_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   t_act, t_act_q, t_edge;
    logic                   tick, presc_en, count_en, timeout;

    assign t_act  = sync_q[SYNC_STAGES-1] ^ pol_q;
    assign t_edge = t_act & ~t_act_q;

    assign presc_en = (mode_q != MODE_STOP) && (mode_q != MODE_EVENT);

    mfp_timer_prescaler u_prescaler (
        .XCLK_I (XCLK_I),
        .RST    (RST),
        .en     (presc_en),
        .div    (prescale_div(mode_q[2:0])),
        .tick   (tick)
    );

    always_comb begin
        count_en = 1'b0;
        if (mode_q == MODE_STOP) begin
            count_en = 1'b0;
        end else if (mode_q == MODE_EVENT) begin
            count_en = t_edge;
        end else if (mode_q[3]) begin
            count_en = tick & t_act;
        end else begin
            count_en = tick;
        end
        // A stopping control write swallows any count in the same cycle
        if (CTRL_WE && (CTRL_I[3:0] == MODE_STOP)) begin
            count_en = 1'b0;
        end
    end

    assign timeout = count_en && (cnt_q == CNT_ONE);

    always_comb begin
        data_d    = DAT_WE ? DAT_I : data_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        oneshot_d = oneshot_q;
        pol_d     = pol_q;
        to_d      = to_q;
        if (count_en) begin
            if (timeout) begin
                cnt_d = DAT_WE ? DAT_I : data_q;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (DAT_WE && (mode_q == MODE_STOP)) begin
            cnt_d = DAT_I;
        end
        if (CTRL_WE) begin
            mode_d    = CTRL_I[3:0];
            oneshot_d = CTRL_I[CTRL_ONESHOT] & (ONESHOT_EN != 0);
            pol_d     = CTRL_I[CTRL_POL];
        end else if (timeout && oneshot_q) begin
            mode_d = MODE_STOP;
        end
        if (CTRL_WE && CTRL_I[CTRL_FORCE_TO]) begin
            to_d = 1'b0;
        end else if (timeout) begin
            to_d = ~to_q;
        end
    end

    always_ff @(posedge XCLK_I) begin
        if (RST) begin
            mode_q    <= MODE_STOP;
            oneshot_q <= 1'b0;
            pol_q     <= 1'b0;
            data_q    <= '0;
            cnt_q     <= '0;
            dat_o_q   <= '0;
            to_q      <= 1'b0;
            pulse_q   <= 1'b0;
            sync_q    <= '0;
            t_act_q   <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            oneshot_q <= oneshot_d;
            pol_q     <= pol_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            pulse_q   <= timeout;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], T_I};
            t_act_q   <= t_act;
            if (!RD_HOLD) begin
                dat_o_q <= cnt_q;
            end
        end
    end

    assign DAT_O        = dat_o_q;
    assign CTRL_O       = {pol_q, oneshot_q, mode_q};
    assign DELAY_MODE   = ~mode_q[3];
    assign T_O          = to_q;
    assign T_O_PULSE    = pulse_q;
    assign SET_DATA_OUT = data_q;

endmodule

// File: tb/tb_mfp_timer_gen.sv
// Directed self-checking bench for mfp_timer_gen (8-bit channel plus a 12-bit wrap check).
module tb_mfp_timer_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dat_we = 1'b0;
    logic [7:0]  dat_i = 8'd0;
    logic [7:0]  dat_o;
    logic        rd_hold = 1'b0;
    logic        ctrl_we = 1'b0;
    logic [6:0]  ctrl_i = 7'd0;
    logic [5:0]  ctrl_o;
    logic        t_i = 1'b0;
    logic        delay_mode, t_o, t_o_pulse;
    logic [7:0]  set_data;

    logic        w_ctrl_we = 1'b0;
    logic [6:0]  w_ctrl_i = 7'd0;
    logic [11:0] w_dat_o, w_set_data;
    logic [5:0]  w_ctrl_o;
    logic        w_delay_mode, w_t_o, w_t_o_pulse;

    int vectors = 0;
    int miscompares = 0;
    int n, nw;

    always #5 clk = ~clk;

    mfp_timer_gen #(.WIDTH(8), .SYNC_STAGES(2), .ONESHOT_EN(1)) u_dut (
        .XCLK_I       (clk),
        .RST          (rst),
        .DAT_WE       (dat_we),
        .DAT_I        (dat_i),
        .DAT_O        (dat_o),
        .RD_HOLD      (rd_hold),
        .CTRL_WE      (ctrl_we),
        .CTRL_I       (ctrl_i),
        .CTRL_O       (ctrl_o),
        .T_I          (t_i),
        .DELAY_MODE   (delay_mode),
        .T_O          (t_o),
        .T_O_PULSE    (t_o_pulse),
        .SET_DATA_OUT (set_data)
    );

    mfp_timer_gen #(.WIDTH(12), .SYNC_STAGES(2), .ONESHOT_EN(1)) u_wide (
        .XCLK_I       (clk),
        .RST          (rst),
        .DAT_WE       (1'b0),
        .DAT_I        (12'd0),
        .DAT_O        (w_dat_o),
        .RD_HOLD      (1'b0),
        .CTRL_WE      (w_ctrl_we),
        .CTRL_I       (w_ctrl_i),
        .CTRL_O       (w_ctrl_o),
        .T_I          (1'b0),
        .DELAY_MODE   (w_delay_mode),
        .T_O          (w_t_o),
        .T_O_PULSE    (w_t_o_pulse),
        .SET_DATA_OUT (w_set_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_dat(input logic [7:0] v);
        dat_we = 1'b1; dat_i = v;
        step();
        dat_we = 1'b0;
    endtask

    task automatic wr_ctrl(input logic [6:0] v);
        ctrl_we = 1'b1; ctrl_i = v;
        step();
        ctrl_we = 1'b0;
    endtask

    // Cycles until the next T_O_PULSE, 0 if none within max
    task automatic wait_pulse(input int max, output int cyc);
        cyc = 0;
        for (int i = 1; i <= max; i++) begin
            step();
            if (t_o_pulse) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Drive T_I to v and report the cycle (1..6) where a pulse appears, 0 if none
    task automatic ev(input logic v, output int cyc);
        t_i = v;
        cyc = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (t_o_pulse && cyc == 0) cyc = i;
        end
    endtask

    initial begin
        // Reset
        steps(2);
        chk("rst_dat_o", dat_o, 0);
        chk("rst_ctrl_o", ctrl_o, 0);
        chk("rst_t_o", t_o, 0);
        chk("rst_pulse", t_o_pulse, 0);
        chk("rst_data", set_data, 0);
        chk("rst_delay_mode", delay_mode, 1);
        rst = 1'b0;
        step();

        // Delay mode, data 3, divider 4
        wr_dat(8'd3);
        chk("stop_load_data", set_data, 3);
        wr_ctrl(7'h01);
        chk("delay_ctrl_o", ctrl_o, 6'h01);
        wait_pulse(40, n);
        chk("delay_first_period", n, 12);
        chk("delay_t_o_1", t_o, 1);
        wait_pulse(40, n);
        chk("delay_second_period", n, 12);
        chk("delay_t_o_2", t_o, 0);
        step();
        chk("dat_o_after_reload", dat_o, 3);

        // Read hold, then forced T_O=0 on a timeout
        rd_hold = 1'b1;
        steps(6);
        chk("rd_hold_frozen", dat_o, 3);
        rd_hold = 1'b0;
        step();
        chk("rd_release_1", dat_o, 2);
        step();
        chk("rd_release_2", dat_o, 1);
        steps(2);
        wr_ctrl(7'h11);
        chk("force_t_o", t_o, 0);
        chk("force_pulse", t_o_pulse, 1);
        wr_ctrl(7'h00);
        chk("stop_ctrl_o", ctrl_o, 0);

        // data 0 means 2^WIDTH counts; 12-bit instance runs in parallel
        wr_dat(8'd0);
        ctrl_we = 1'b1; ctrl_i = 7'h01;
        w_ctrl_we = 1'b1; w_ctrl_i = 7'h01;
        step();
        ctrl_we = 1'b0; w_ctrl_we = 1'b0;
        n = 0; nw = 0;
        for (int i = 1; i <= 17000; i++) begin
            step();
            if (t_o_pulse && n == 0) n = i;
            if (w_t_o_pulse) begin
                nw = i;
                break;
            end
        end
        chk("wrap_8bit", n, 1024);
        chk("wrap_12bit", nw, 16384);
        wr_ctrl(7'h00);
        w_ctrl_we = 1'b1; w_ctrl_i = 7'h00;
        step();
        w_ctrl_we = 1'b0;

        // Event mode, rising edges, data 2
        wr_dat(8'd2);
        wr_ctrl(7'h08);
        chk("event_delay_mode", delay_mode, 0);
        ev(1'b1, n); chk("ev_r1", n, 0);
        ev(1'b0, n); chk("ev_f1", n, 0);
        ev(1'b1, n); chk("ev_r2_latency", n, 3);
        ev(1'b0, n); chk("ev_f2", n, 0);
        ev(1'b1, n); chk("ev_r3", n, 0);
        ev(1'b0, n); chk("ev_f3", n, 0);
        ev(1'b1, n); chk("ev_r4_latency", n, 3);

        // Event mode, active low: falling T_I edges count
        wr_ctrl(7'h48);
        chk("event_pol_ctrl_o", ctrl_o, 6'h28);
        ev(1'b0, n); chk("evp_f1", n, 0);
        ev(1'b1, n); chk("evp_r1", n, 0);
        ev(1'b0, n); chk("evp_f2_latency", n, 3);
        wr_ctrl(7'h00);

        // Pulse mode, data 5, gated by T_I
        wr_dat(8'd5);
        t_i = 1'b1;
        steps(4);
        wr_ctrl(7'h09);
        chk("pulse_delay_mode", delay_mode, 0);
        steps(9);
        t_i = 1'b0;
        step();
        chk("pulse_two_ticks", dat_o, 3);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (t_o_pulse) n++;
        end
        chk("pulse_gate_low_hold", dat_o, 3);
        chk("pulse_gate_low_nopulse", n, 0);
        t_i = 1'b1;
        wait_pulse(40, n);
        chk("pulse_regate_timeout", n, 14);
        wr_ctrl(7'h00);
        t_i = 1'b0;
        steps(4);

        // One-shot delay, data 2
        wr_dat(8'd2);
        wr_ctrl(7'h21);
        wait_pulse(40, n);
        chk("oneshot_period", n, 8);
        chk("oneshot_stopped", ctrl_o, 6'h10);
        step();
        chk("oneshot_reload", dat_o, 2);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (t_o_pulse) n++;
        end
        chk("oneshot_no_more", n, 0);
        chk("oneshot_cnt_held", dat_o, 2);

        // Reset mid-count
        wr_ctrl(7'h01);
        steps(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_ctrl_o", ctrl_o, 0);
        chk("midrst_data", set_data, 0);
        chk("midrst_t_o", t_o, 0);
        step();
        chk("midrst_dat_o", dat_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
